// File: rtl/isi_channel_cfg_if.sv
// Sample stream, tap configuration and flush control bundle for isi_channel_cfg.
interface isi_channel_cfg_if #(
    parameter int unsigned PULSE_RESPONSE_LENGTH = 5,
    parameter int unsigned SIGNAL_RESOLUTION     = 8,
    parameter int unsigned COEFF_WIDTH           = 8,
    parameter int unsigned SHIFT_WIDTH           = 5
);
    localparam int unsigned AW = $clog2(PULSE_RESPONSE_LENGTH);

    // Input sample stream
    logic signed [SIGNAL_RESOLUTION-1:0] signal_in;
    logic                                signal_in_valid;
    logic                                signal_in_ready;

    // Output sample stream
    logic signed [SIGNAL_RESOLUTION-1:0] signal_out;
    logic                                signal_out_valid;
    logic                                signal_out_ready;

    // Tap and exponent configuration
    logic                                cfg_wr;
    logic [AW-1:0]                       cfg_addr;
    logic signed [COEFF_WIDTH-1:0]       cfg_coeff;
    logic                                cfg_shift_wr;
    logic [SHIFT_WIDTH-1:0]              cfg_shift;

    // Tail drain control and status
    logic                                flush_req;
    logic                                flush_done;
    logic                                sat_flag;

    modport master (
        output signal_in, signal_in_valid, signal_out_ready,
        output cfg_wr, cfg_addr, cfg_coeff, cfg_shift_wr, cfg_shift, flush_req,
        input  signal_in_ready, signal_out, signal_out_valid, flush_done, sat_flag
    );

    modport slave (
        input  signal_in, signal_in_valid, signal_out_ready,
        input  cfg_wr, cfg_addr, cfg_coeff, cfg_shift_wr, cfg_shift, flush_req,
        output signal_in_ready, signal_out, signal_out_valid, flush_done, sat_flag
    );
endinterface

// File: rtl/isi_channel_cfg.sv
// Configurable ISI channel model: transposed-form FIR over PAM samples with a
// global arithmetic right shift, output saturation and an ISI tail flush.
module isi_channel_cfg #(
    parameter int unsigned PULSE_RESPONSE_LENGTH = 5,
    parameter int unsigned SIGNAL_RESOLUTION     = 8,
    parameter int unsigned COEFF_WIDTH           = 8,
    parameter int unsigned SHIFT_WIDTH           = 5
) (
    input  logic             clk,
    input  logic             rst,
    isi_channel_cfg_if.slave bus
);
    localparam int unsigned L     = PULSE_RESPONSE_LENGTH;
    localparam int unsigned R     = SIGNAL_RESOLUTION;
    localparam int unsigned C     = COEFF_WIDTH;
    localparam int unsigned S     = SHIFT_WIDTH;
    localparam int unsigned AW    = $clog2(L);
    localparam int unsigned ACC_W = R + C + AW;
    localparam int unsigned CNT_W = AW;

    // Last flush fire index: L-1 zero samples drain L-1 partial sums
    localparam logic [CNT_W-1:0]        FLUSH_LAST = CNT_W'(L - 2);
    localparam logic signed [ACC_W-1:0] OUT_MAX    = ACC_W'((2 ** (R - 1)) - 1);
    localparam logic signed [ACC_W-1:0] OUT_MIN    = ~OUT_MAX;
    // Identity channel: h[0] = 2^(C-2) with shift C-2
    localparam logic signed [C-1:0]     TAP0_RST   = C'(2 ** (C - 2));
    localparam logic [S-1:0]            SHIFT_RST  = S'(C - 2);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [CNT_W-1:0]        cnt_q;
    logic [CNT_W-1:0]        cnt_d;
    logic                    flush_done_d;

    logic signed [C-1:0]     taps_q [L];
    logic [S-1:0]            shift_q;
    // isi_q[k] holds the contribution of past samples to the output k+1 fires ahead
    logic signed [ACC_W-1:0] isi_q  [L-1];

    logic signed [ACC_W-1:0] prod_c [L];
    logic signed [R-1:0]     x_c;
    logic signed [ACC_W-1:0] sum_c;
    logic signed [ACC_W-1:0] shifted_c;
    logic signed [R-1:0]     y_c;
    logic                    clamp_c;
    logic                    can_accept_c;
    logic                    fire_c;

    // Handshake: a sample slot is free when the output register is empty or draining
    assign can_accept_c        = !bus.signal_out_valid || bus.signal_out_ready;
    assign bus.signal_in_ready = (state_q == ST_RUN) && can_accept_c;
    assign fire_c              = can_accept_c && ((state_q == ST_FLUSH) || bus.signal_in_valid);
    assign x_c                 = (state_q == ST_RUN) ? bus.signal_in : '0;

    // Tap products, sign-extended to full accumulator width before multiplying
    always_comb begin
        for (int k = 0; k < int'(L); k++) begin
            prod_c[k] = ACC_W'(taps_q[k]) * ACC_W'(x_c);
        end
    end

    // Output sum, exponent shift and saturation to R bits
    always_comb begin
        sum_c     = prod_c[0] + isi_q[0];
        shifted_c = sum_c >>> shift_q;
        clamp_c   = 1'b0;
        y_c       = R'(shifted_c);
        if (shifted_c > OUT_MAX) begin
            y_c     = R'(OUT_MAX);
            clamp_c = 1'b1;
        end else if (shifted_c < OUT_MIN) begin
            y_c     = R'(OUT_MIN);
            clamp_c = 1'b1;
        end
    end

    // Control state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_RUN;
            cnt_q          <= '0;
            bus.flush_done <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            bus.flush_done <= flush_done_d;
        end
    end

    // Next state: enter FLUSH on request, leave after the last zero-sample fire
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        flush_done_d = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (bus.flush_req) begin
                    state_d = ST_FLUSH;
                    cnt_d   = '0;
                end
            end
            ST_FLUSH: begin
                if (fire_c) begin
                    if (cnt_q == FLUSH_LAST) begin
                        state_d      = ST_RUN;
                        cnt_d        = '0;
                        flush_done_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // Tap and exponent registers; out-of-range tap addresses are dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < int'(L); k++) begin
                taps_q[k] <= (k == 0) ? TAP0_RST : '0;
            end
            shift_q <= SHIFT_RST;
        end else begin
            if (bus.cfg_wr && (32'(bus.cfg_addr) < L)) begin
                taps_q[bus.cfg_addr] <= bus.cfg_coeff;
            end
            if (bus.cfg_shift_wr) begin
                shift_q <= bus.cfg_shift;
            end
        end
    end

    // Partial-sum pipeline advances only on fire
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < int'(L) - 1; k++) begin
                isi_q[k] <= '0;
            end
        end else if (fire_c) begin
            for (int k = 0; k < int'(L) - 2; k++) begin
                isi_q[k] <= isi_q[k+1] + prod_c[k+1];
            end
            isi_q[L-2] <= prod_c[L-1];
        end
    end

    // Output register with hold under backpressure and sticky saturation flag
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.signal_out       <= '0;
            bus.signal_out_valid <= 1'b0;
            bus.sat_flag         <= 1'b0;
        end else if (fire_c) begin
            bus.signal_out       <= y_c;
            bus.signal_out_valid <= 1'b1;
            if (clamp_c) begin
                bus.sat_flag <= 1'b1;
            end
        end else if (bus.signal_out_ready) begin
            bus.signal_out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_isi_channel_cfg.sv
// Self-checking bench for isi_channel_cfg (L=4, R=8, C=8, S=5).
module tb_isi_channel_cfg;
    localparam int unsigned L = 4;
    localparam int unsigned R = 8;
    localparam int unsigned C = 8;
    localparam int unsigned S = 5;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    // Reference model state for the randomized run
    int   m_h [L];
    int   m_shift;
    int   m_x [$];
    bit   m_flush, m_ov, m_fd, m_sat;
    int   m_cnt, m_out;

    always #5 clk = ~clk;

    isi_channel_cfg_if #(
        .PULSE_RESPONSE_LENGTH(L), .SIGNAL_RESOLUTION(R),
        .COEFF_WIDTH(C), .SHIFT_WIDTH(S)
    ) bus ();

    isi_channel_cfg #(
        .PULSE_RESPONSE_LENGTH(L), .SIGNAL_RESOLUTION(R),
        .COEFF_WIDTH(C), .SHIFT_WIDTH(S)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.signal_in        = '0;
        bus.signal_in_valid  = 1'b0;
        bus.signal_out_ready = 1'b1;
        bus.cfg_wr           = 1'b0;
        bus.cfg_addr         = '0;
        bus.cfg_coeff        = '0;
        bus.cfg_shift_wr     = 1'b0;
        bus.cfg_shift        = '0;
        bus.flush_req        = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic write_tap(input int a, input int v);
        bus.cfg_wr    = 1'b1;
        bus.cfg_addr  = 2'(a);
        bus.cfg_coeff = C'(v);
        tick();
        bus.cfg_wr    = 1'b0;
    endtask

    task automatic write_shift(input int v);
        bus.cfg_shift_wr = 1'b1;
        bus.cfg_shift    = S'(v);
        tick();
        bus.cfg_shift_wr = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        bus.signal_in       = 8'sd99;
        bus.signal_in_valid = 1'b1;
        bus.flush_req       = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        bus.signal_in_valid = 1'b0;
        bus.flush_req       = 1'b0;
        #1;
        checks++; if (bus.signal_out !== R'(0)) begin errors++; $display("FAIL reset_out got %0d exp 0", bus.signal_out); end
        checks++; if (bus.signal_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus.signal_out_valid); end
        checks++; if (bus.flush_done !== 1'b0) begin errors++; $display("FAIL reset_flush_done got %b exp 0", bus.flush_done); end
        checks++; if (bus.sat_flag !== 1'b0) begin errors++; $display("FAIL reset_sat got %b exp 0", bus.sat_flag); end
        checks++; if (bus.signal_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", bus.signal_in_ready); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_identity();
        int xin [2] = '{56, -16};
        for (int i = 0; i < 2; i++) begin
            bus.signal_in       = R'(xin[i]);
            bus.signal_in_valid = 1'b1;
            tick();
            checks++; if (bus.signal_out_valid !== 1'b1) begin errors++; $display("FAIL ident_valid%0d got %b exp 1", i, bus.signal_out_valid); end
            checks++; if (bus.signal_out !== R'(xin[i])) begin errors++; $display("FAIL ident_out%0d got %0d exp %0d", i, bus.signal_out, xin[i]); end
        end
        bus.signal_in_valid = 1'b0;
        tick();
        checks++; if (bus.signal_out_valid !== 1'b0) begin errors++; $display("FAIL ident_valid_clear got %b exp 0", bus.signal_out_valid); end
    endtask

    task automatic test_taps();
        int xin [3] = '{56, 0, 0};
        int yex [3] = '{56, 28, 0};
        write_tap(1, 32);
        write_shift(6);
        for (int i = 0; i < 3; i++) begin
            bus.signal_in       = R'(xin[i]);
            bus.signal_in_valid = 1'b1;
            tick();
            checks++; if (bus.signal_out !== R'(yex[i])) begin errors++; $display("FAIL taps_out%0d got %0d exp %0d", i, bus.signal_out, yex[i]); end
        end
        bus.signal_in_valid = 1'b0;
        checks++; if (bus.sat_flag !== 1'b0) begin errors++; $display("FAIL taps_sat got %b exp 0", bus.sat_flag); end
        tick();
    endtask

    task automatic test_saturation();
        do_reset();
        write_tap(0, 127);
        write_shift(0);
        bus.signal_in       = 8'sd100;
        bus.signal_in_valid = 1'b1;
        tick();
        checks++; if (bus.signal_out !== R'(127)) begin errors++; $display("FAIL sat_out got %0d exp 127", bus.signal_out); end
        checks++; if (bus.sat_flag !== 1'b1) begin errors++; $display("FAIL sat_flag_set got %b exp 1", bus.sat_flag); end
        bus.signal_in = '0;
        tick();
        checks++; if (bus.signal_out !== R'(0)) begin errors++; $display("FAIL sat_out_zero got %0d exp 0", bus.signal_out); end
        checks++; if (bus.sat_flag !== 1'b1) begin errors++; $display("FAIL sat_flag_sticky got %b exp 1", bus.sat_flag); end
        bus.signal_in_valid = 1'b0;
        do_reset();
        checks++; if (bus.sat_flag !== 1'b0) begin errors++; $display("FAIL sat_flag_reset got %b exp 0", bus.sat_flag); end
    endtask

    task automatic test_flush();
        int first [2] = '{16, 32};
        int tail  [2][3] = '{'{8, 4, 2}, '{16, 8, 4}};
        do_reset();
        write_tap(0, 64);
        write_tap(1, 32);
        write_tap(2, 16);
        write_tap(3, 8);
        write_shift(6);
        for (int r = 0; r < 2; r++) begin
            // Round 0: flush after the sample; round 1: flush together with the sample
            bus.signal_in       = R'(first[r]);
            bus.signal_in_valid = 1'b1;
            bus.flush_req       = (r == 1);
            tick();
            checks++; if (bus.signal_out !== R'(first[r])) begin errors++; $display("FAIL flush%0d_first got %0d exp %0d", r, bus.signal_out, first[r]); end
            bus.signal_in_valid = 1'b0;
            if (r == 0) begin
                bus.flush_req = 1'b1;
                tick();
            end
            bus.flush_req = 1'b0;
            #1;
            checks++; if (bus.signal_in_ready !== 1'b0) begin errors++; $display("FAIL flush%0d_in_ready got %b exp 0", r, bus.signal_in_ready); end
            for (int i = 0; i < 3; i++) begin
                tick();
                checks++; if (bus.signal_out_valid !== 1'b1 || bus.signal_out !== R'(tail[r][i])) begin
                    errors++; $display("FAIL flush%0d_tail%0d got %0d/%b exp %0d/1", r, i, bus.signal_out, bus.signal_out_valid, tail[r][i]); end
                checks++; if (bus.flush_done !== (i == 2)) begin errors++; $display("FAIL flush%0d_done%0d got %b exp %b", r, i, bus.flush_done, (i == 2)); end
                checks++; if (bus.signal_in_ready !== (i == 2)) begin errors++; $display("FAIL flush%0d_ready%0d got %b exp %b", r, i, bus.signal_in_ready, (i == 2)); end
            end
            tick();
            checks++; if (bus.flush_done !== 1'b0) begin errors++; $display("FAIL flush%0d_done_pulse got %b exp 0", r, bus.flush_done); end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        write_tap(1, 32);
        bus.signal_out_ready = 1'b0;
        bus.signal_in        = 8'sd56;
        bus.signal_in_valid  = 1'b1;
        tick();
        bus.signal_in = 8'sd10;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (bus.signal_out !== R'(56) || bus.signal_out_valid !== 1'b1) begin
                errors++; $display("FAIL bp_hold%0d got %0d/%b exp 56/1", i, bus.signal_out, bus.signal_out_valid); end
            checks++; if (bus.signal_in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready%0d got %b exp 0", i, bus.signal_in_ready); end
        end
        bus.signal_out_ready = 1'b1;
        #1;
        checks++; if (bus.signal_in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b exp 1", bus.signal_in_ready); end
        tick();
        // (64*10 + 32*56) >>> 6 = 38 only if the held cycles left partials untouched
        checks++; if (bus.signal_out !== R'(38)) begin errors++; $display("FAIL bp_next_out got %0d exp 38", bus.signal_out); end
        bus.signal_in_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_flush();
        do_reset();
        write_tap(1, 32);
        write_tap(2, 16);
        write_tap(3, 8);
        bus.signal_in       = 8'sd16;
        bus.signal_in_valid = 1'b1;
        bus.flush_req       = 1'b1;
        tick();
        bus.signal_in_valid = 1'b0;
        bus.flush_req       = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++; if (bus.signal_in_ready !== 1'b1) begin errors++; $display("FAIL rstflush_ready got %b exp 1", bus.signal_in_ready); end
        checks++; if (bus.signal_out !== R'(0) || bus.signal_out_valid !== 1'b0) begin
            errors++; $display("FAIL rstflush_out got %0d/%b exp 0/0", bus.signal_out, bus.signal_out_valid); end
        checks++; if (bus.flush_done !== 1'b0) begin errors++; $display("FAIL rstflush_done got %b exp 0", bus.flush_done); end
        bus.signal_in       = 8'sd56;
        bus.signal_in_valid = 1'b1;
        tick();
        checks++; if (bus.signal_out !== R'(56)) begin errors++; $display("FAIL rstflush_ident got %0d exp 56", bus.signal_out); end
        bus.signal_in = '0;
        tick();
        checks++; if (bus.signal_out !== R'(0)) begin errors++; $display("FAIL rstflush_tail got %0d exp 0", bus.signal_out); end
        bus.signal_in_valid = 1'b0;
        tick();
    endtask

    // Direct-form convolution of the accepted-sample history, floor shift, clamp
    task automatic model_fire(input int x);
        longint acc;
        longint y;
        m_x.push_front(x);
        void'(m_x.pop_back());
        acc = 0;
        for (int k = 0; k < int'(L); k++) acc += longint'(m_h[k]) * longint'(m_x[k]);
        y = acc >>> m_shift;
        if (y > 127) begin y = 127; m_sat = 1'b1; end
        else if (y < -128) begin y = -128; m_sat = 1'b1; end
        m_out = int'(y);
        m_ov  = 1'b1;
    endtask

    task automatic test_random();
        bit vin, ordy, freq, ready, fire;
        int sin;
        do_reset();
        for (int k = 0; k < int'(L); k++) begin
            m_h[k] = int'($urandom_range(255)) - 128;
            write_tap(k, m_h[k]);
        end
        m_shift = int'($urandom_range(9));
        write_shift(m_shift);
        m_x.delete();
        for (int k = 0; k < int'(L); k++) m_x.push_back(0);
        m_flush = 0; m_ov = 0; m_fd = 0; m_sat = 0; m_cnt = 0; m_out = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            vin  = ($urandom_range(3) != 0);
            ordy = ($urandom_range(3) != 0);
            freq = ($urandom_range(24) == 0);
            sin  = int'($urandom_range(255)) - 128;
            bus.signal_in        = R'(sin);
            bus.signal_in_valid  = vin;
            bus.signal_out_ready = ordy;
            bus.flush_req        = freq;
            ready = !m_flush && (!m_ov || ordy);
            fire  = m_flush ? (!m_ov || ordy) : (vin && ready);
            #1;
            checks++; if (bus.signal_in_ready !== ready) begin errors++; $display("FAIL rnd_ready c%0d got %b exp %b", cyc, bus.signal_in_ready, ready); end
            if (fire) model_fire(m_flush ? 0 : sin);
            else if (ordy) m_ov = 1'b0;
            m_fd = 1'b0;
            if (!m_flush) begin
                if (freq) begin m_flush = 1'b1; m_cnt = 0; end
            end else if (fire) begin
                m_cnt++;
                if (m_cnt == int'(L) - 1) begin m_flush = 1'b0; m_fd = 1'b1; end
            end
            tick();
            checks++; if (bus.signal_out_valid !== m_ov) begin errors++; $display("FAIL rnd_valid c%0d got %b exp %b", cyc, bus.signal_out_valid, m_ov); end
            if (m_ov) begin
                checks++; if (bus.signal_out !== R'(m_out)) begin errors++; $display("FAIL rnd_out c%0d got %0d exp %0d", cyc, bus.signal_out, m_out); end
            end
            checks++; if (bus.flush_done !== m_fd) begin errors++; $display("FAIL rnd_flush_done c%0d got %b exp %b", cyc, bus.flush_done, m_fd); end
            checks++; if (bus.sat_flag !== m_sat) begin errors++; $display("FAIL rnd_sat c%0d got %b exp %b", cyc, bus.sat_flag, m_sat); end
        end
        idle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_identity();
        test_taps();
        test_saturation();
        test_flush();
        test_backpressure();
        test_reset_mid_flush();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
